// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a FIFO built on a 2-port memory.
// Drives memory enables and addresses and decodes occupancy and error flags.
module fifo_ctrl #(
    parameter int unsigned addrs_width     = 8,
    parameter int unsigned almost_full_th  = 4,
    parameter int unsigned almost_empty_th = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_req,
    input  logic                   rd_req,
    output logic                   mem_write_enable,
    output logic [addrs_width-1:0] mem_write_address,
    output logic                   mem_read_enable,
    output logic [addrs_width-1:0] mem_read_address,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [addrs_width:0]   count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam logic [addrs_width:0] DEPTH_V = {1'b1, {addrs_width{1'b0}}};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [addrs_width:0] r_wr_ptr;
    logic [addrs_width:0] r_rd_ptr;
    logic                 r_rd_valid;
    logic                 r_overflow;
    logic                 r_underflow;

    logic [addrs_width:0] w_count;
    logic [addrs_width:0] w_free;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_almost_full;
    logic                 w_almost_empty;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_wr_reject;
    logic                 w_rd_reject;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_empty        = (r_wr_ptr == r_rd_ptr);
        w_full         = (r_wr_ptr[addrs_width-1:0] == r_rd_ptr[addrs_width-1:0]) &&
                         (r_wr_ptr[addrs_width] != r_rd_ptr[addrs_width]);
        w_count        = r_wr_ptr - r_rd_ptr;
        w_free         = DEPTH_V - w_count;
        w_almost_full  = (32'(w_free) <= almost_full_th);
        w_almost_empty = (32'(w_count) <= almost_empty_th);

        // Acceptance uses this cycle's flags; reset blocks both memory accesses.
        w_wr_acc       = wr_req & ~w_full & ~rst;
        w_rd_acc       = rd_req & ~w_empty & ~rst;
        w_wr_reject    = wr_req & w_full;
        w_rd_reject    = rd_req & w_empty;
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + {{addrs_width{1'b0}}, w_wr_acc};
            r_rd_ptr   <= r_rd_ptr + {{addrs_width{1'b0}}, w_rd_acc};
            r_rd_valid <= w_rd_acc;
            if (w_wr_reject) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_reject) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign mem_write_enable  = w_wr_acc;
    assign mem_read_enable   = w_rd_acc;
    assign mem_write_address = r_wr_ptr[addrs_width-1:0];
    assign mem_read_address  = r_rd_ptr[addrs_width-1:0];
    assign rd_valid          = r_rd_valid;
    assign full              = w_full;
    assign empty             = w_empty;
    assign almost_full       = w_almost_full;
    assign almost_empty      = w_almost_empty;
    assign count             = w_count;
    assign overflow          = r_overflow;
    assign underflow         = r_underflow;

endmodule
